tick_gen: RTL and testbench
===========================

# tick_gen

Parametrised multi-channel tick generator for the scoreboard and later lab designs. It generates single-cycle clock-enable pulses (`tick`) and 50 % square waves (`sq`) from one system clock. Each channel has its own divisor, loadable at run time, plus a per-channel pause and a global phase-align strobe. Downstream logic runs entirely on `clk` and qualifies its work with `tick`, so there are no derived clock domains.

## Interface
Parameters:
- `NCH`, 3, number of channels (1..8)
- `CW`, 27, width of the divisor and counter per channel
- `DIV_INIT`, {27'd500000, 27'd50000, 27'd100000000}, packed NCH×CW reset divisors; channel i is bits [i*CW +: CW], so ch0 = 1 Hz tick, ch1 = 2 kHz tick, ch2 = 200 Hz tick at 100 MHz

Ports:
- `clk` in 1: system clock, 100 MHz on board
- `rst` in 1: synchronous, active-high reset
- `en` in NCH: per-channel run enable; 0 = paused
- `sync` in 1: one-cycle strobe that phase-aligns all channels
- `ld` in 1: one-cycle strobe that loads a divisor
- `ld_ch` in $clog2(NCH) (min 1): channel selected by `ld`; values ≥ NCH are ignored
- `ld_div` in CW: new divisor
- `tick` out NCH: one-cycle pulse per channel period
- `sq` out NCH: square wave, toggles on each tick, period 2×div
- `div_q` out NCH×CW: current divisor of every channel

## Operation
- Per-channel state: `div` (CW), `cnt` (CW), `sq`, `tick`. All outputs are registered.
- Reset (`rst`=1 at a clk edge):
  - cnt=0, tick=0, sq=0, div=DIV_INIT.
  - `rst` has priority over every other input, including mid-period.
- Normal count, when en[i]=1 and div≥1:
  - If cnt==div-1: cnt←0, tick←1, sq←~sq.
  - Otherwise: cnt←cnt+1, tick←0.
- Resulting rates: tick period = div cycles; sq period = 2×div cycles.
- div==1: tick is held high continuously and sq toggles every cycle.
- div==0: channel is halted. cnt←0, tick←0, sq holds.
- Pause (en[i]=0): cnt and sq hold, tick←0. On resume, counting continues from the held cnt, so no period is lost or shortened.
- Load (`ld`=1, ld_ch=i<NCH), for channel i only:
  - div←ld_div, cnt←0, tick←0, sq holds.
  - The first tick under the new divisor comes ld_div cycles after the load edge.
- Sync (`sync`=1): every channel sets cnt←0, tick←0, sq←0, regardless of en.
- Priority per channel: rst > ld (for the addressed channel) > sync > pause/halt > count.
  - ld together with sync: the addressed channel takes the new div; every channel gets cnt=0, and sq=0 on all channels except the addressed one, which holds sq.
  - ld on the terminal-count cycle: load wins and no tick is emitted.
  - sync on the terminal-count cycle: no tick.
- Counter arithmetic is CW bits wide. The compare uses div-1 computed in CW bits and is only evaluated when div≥1. cnt never exceeds div-1, so there is no wrap-around.
- `div_q` reflects the div registers. It updates on the edge after `ld`.

## Timing
- Single clock domain. All inputs are sampled on the rising edge of clk. `en`, `ld_*` and `sync` must already be synchronous to clk; debouncing belongs upstream.
- Reset: `rst` is released at edge 0. For div=D≥2, the first tick is high in the cycle after edge D, and the following ticks after edges 2D, 3D, and so on. sq first rises with the first tick.
- Latency:
  - ld/sync to effect: 1 cycle.
  - en falling to tick suppressed: 1 cycle.
- tick width is exactly 1 cycle for div≥2.

## Test plan
Run with NCH=3, CW=8, DIV_INIT={8'd2, 8'd3, 8'd5}, en=3'b111.
- Reset release, run 30 cycles:
  - tick[0] every 5 cycles (first after edge 5), tick[1] every 3, tick[2] every 2.
  - sq[0] period 10; all outputs 0 during rst.
- ld with ld_ch=1, ld_div=4 at an arbitrary cycle:
  - div_q ch1=4 on the next cycle, tick[1] suppressed, next tick[1] 4 cycles after the load edge, then every 4.
  - ld_ch=3 changes nothing.
- ld_div=0 on ch0: tick[0] and cnt stay 0, sq[0] holds.
- ld_div=1 on ch0: tick[0] held high, sq[0] toggles every cycle.
- en[0] cleared for 7 cycles at cnt=2, then set: no tick while paused; the next tick comes 2 cycles after resume (cnt continues 3, 4).
- Corner cases:
  - sync on ch0's terminal-count cycle, with ld on ch2 in the same cycle: no tick[0]; all cnt=0; sq[0]=sq[1]=0 while sq[2] holds; ch2 takes the new div.
  - rst asserted mid-period: all outputs and div return to DIV_INIT values on the next edge.

Source files
------------

// File: rtl/tick_gen.sv
// tick_gen: multi-channel tick and square-wave generator.
// Every channel counts system-clock cycles up to its own run-time loadable
// divisor and emits a one-cycle clock-enable pulse (tick) at the end of
// each period, plus a 50 % square wave (sq) that toggles on every tick.
// Downstream logic stays on clk and qualifies its work with tick, so this
// block never creates a derived clock.
module tick_gen #(
   parameter int NCH = 3,
   parameter int CW = 27,
   parameter logic [NCH*CW-1:0] DIV_INIT = {27'd500000, 27'd50000, 27'd100000000},
   localparam int LDW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    en,
   input  logic              sync,
   input  logic              ld,
   input  logic [LDW-1:0]    ld_ch,
   input  logic [CW-1:0]     ld_div,
   output logic [NCH-1:0]    tick,
   output logic [NCH-1:0]    sq,
   output logic [NCH*CW-1:0] div_q
);

   // Per-channel state, packed with channel i at [i*CW +: CW]
   logic [NCH*CW-1:0] div_d;
   logic [NCH*CW-1:0] cnt_d;
   logic [NCH*CW-1:0] cnt_q;
   logic [NCH-1:0]    tick_d;
   logic [NCH-1:0]    tick_q;
   logic [NCH-1:0]    sq_d;
   logic [NCH-1:0]    sq_q;

   // Per-channel decode of the load target, halt and terminal-count conditions
   logic [NCH-1:0]    ld_hit;
   logic [NCH-1:0]    div_zero;
   logic [NCH-1:0]    at_term;

   assign tick = tick_q;
   assign sq   = sq_q;

   // Decode which channel a load addresses and where each counter stands.
   // An out-of-range ld_ch matches no channel, so the load is dropped.
   // The terminal compare is qualified by div != 0, so div-1 never wraps.
   always_comb begin
      ld_hit   = '0;
      div_zero = '0;
      at_term  = '0;
      for (int i = 0; i < NCH; i++) begin
         ld_hit[i]   = ld && (ld_ch == LDW'(i));
         div_zero[i] = (div_q[i*CW +: CW] == '0);
         at_term[i]  = !div_zero[i] &&
                       (cnt_q[i*CW +: CW] == (div_q[i*CW +: CW] - CW'(1)));
      end
   end

   // Next-state for every channel, priority: load > sync > pause > halt > count.
   // tick defaults low so it is a single-cycle pulse unless div is 1.
   always_comb begin
      div_d  = div_q;
      cnt_d  = cnt_q;
      sq_d   = sq_q;
      tick_d = '0;
      for (int i = 0; i < NCH; i++) begin
         if (ld_hit[i]) begin
            div_d[i*CW +: CW] = ld_div;
            cnt_d[i*CW +: CW] = '0;
         end else if (sync) begin
            cnt_d[i*CW +: CW] = '0;
            sq_d[i]           = 1'b0;
         end else if (!en[i]) begin
            cnt_d[i*CW +: CW] = cnt_q[i*CW +: CW];
         end else if (div_zero[i]) begin
            cnt_d[i*CW +: CW] = '0;
         end else if (at_term[i]) begin
            cnt_d[i*CW +: CW] = '0;
            tick_d[i]         = 1'b1;
            sq_d[i]           = ~sq_q[i];
         end else begin
            cnt_d[i*CW +: CW] = cnt_q[i*CW +: CW] + CW'(1);
         end
      end
   end

   // State registers; reset restores the power-on divisors and clears the rest
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= DIV_INIT;
         cnt_q  <= '0;
         tick_q <= '0;
         sq_q   <= '0;
      end else begin
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         sq_q   <= sq_d;
      end
   end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: self-checking bench for tick_gen with three 8-bit channels
// whose reset divisors are 5, 3 and 2.
module tb_tick_gen;

   localparam int NCH = 3;
   localparam int CW  = 8;
   localparam logic [NCH*CW-1:0] DIV_INIT = {8'd2, 8'd3, 8'd5};

   logic              clk;
   logic              rst;
   logic [NCH-1:0]    en;
   logic              sync;
   logic              ld;
   logic [1:0]        ld_ch;
   logic [CW-1:0]     ld_div;
   logic [NCH-1:0]    tick;
   logic [NCH-1:0]    sq;
   logic [NCH*CW-1:0] div_q;

   typedef struct {
      logic [2:0] en;
      logic [2:0] exp_tick;
      logic [2:0] exp_sq;
   } vec_t;

   typedef struct {
      logic [2:0]  tick;
      logic [2:0]  sq;
      logic [23:0] div;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[10];

   int checks = 0;
   int errors = 0;

   // Reference model: cycles remaining until the next tick on each channel
   int         m_div[NCH];
   int         m_rem[NCH];
   logic [2:0] m_sq;
   logic [2:0] m_tick;

   tick_gen #(
      .NCH(NCH),
      .CW(CW),
      .DIV_INIT(DIV_INIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .sync(sync),
      .ld(ld),
      .ld_ch(ld_ch),
      .ld_div(ld_div),
      .tick(tick),
      .sq(sq),
      .div_q(div_q)
   );

   // 100 MHz system clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, required end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance the reference model by one clock edge
   task automatic modelStep(input logic r, input logic [2:0] e, input logic s,
                            input logic l, input logic [1:0] lc, input logic [7:0] ld_d);
      for (int i = 0; i < NCH; i++) begin
         if (r) begin
            m_div[i]  = int'(DIV_INIT[i*CW +: CW]);
            m_rem[i]  = m_div[i];
            m_sq[i]   = 1'b0;
            m_tick[i] = 1'b0;
         end else if (l && int'(lc) == i) begin
            m_div[i]  = int'(ld_d);
            m_rem[i]  = m_div[i];
            m_tick[i] = 1'b0;
         end else if (s) begin
            m_rem[i]  = m_div[i];
            m_sq[i]   = 1'b0;
            m_tick[i] = 1'b0;
         end else if (!e[i] || m_div[i] == 0) begin
            m_tick[i] = 1'b0;
         end else if (m_rem[i] == 1) begin
            m_tick[i] = 1'b1;
            m_sq[i]   = ~m_sq[i];
            m_rem[i]  = m_div[i];
         end else begin
            m_rem[i]  = m_rem[i] - 1;
            m_tick[i] = 1'b0;
         end
      end
   endtask

   // Pop the oldest expectation and compare it with what the DUT shows now
   task automatic checkOutput();
      exp_t x;
      if (exp_q.size() == 0) begin
         errors++;
         checks++;
         $display("[TB] FAIL scoreboard: got empty queue, required an entry");
         return;
      end
      x = exp_q.pop_front();
      checks++;
      if (tick !== x.tick) begin
         errors++;
         $display("[TB] FAIL %s tick: got %b required %b at %0t", x.name, tick, x.tick, $time);
      end
      checks++;
      if (sq !== x.sq) begin
         errors++;
         $display("[TB] FAIL %s sq: got %b required %b at %0t", x.name, sq, x.sq, $time);
      end
      checks++;
      if (div_q !== x.div) begin
         errors++;
         $display("[TB] FAIL %s div_q: got %h required %h at %0t", x.name, div_q, x.div, $time);
      end
   endtask

   // Drive one cycle of inputs, queue the expectation, then check after the edge.
   // With use_tab set the tick/sq expectation comes from a hand-written table row.
   task automatic applyStimulus(input logic r, input logic [2:0] e, input logic s,
                                input logic l, input logic [1:0] lc, input logic [7:0] ld_d,
                                input string name, input bit use_tab,
                                input logic [2:0] t_tick, input logic [2:0] t_sq);
      exp_t x;
      rst    = r;
      en     = e;
      sync   = s;
      ld     = l;
      ld_ch  = lc;
      ld_div = ld_d;
      modelStep(r, e, s, l, lc, ld_d);
      x.tick = use_tab ? t_tick : m_tick;
      x.sq   = use_tab ? t_sq : m_sq;
      x.div  = {m_div[2][7:0], m_div[1][7:0], m_div[0][7:0]};
      x.name = name;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic idle(input int n, input logic [2:0] e, input string name);
      for (int k = 0; k < n; k++)
         applyStimulus(1'b0, e, 1'b0, 1'b0, 2'd0, 8'd0, name, 1'b0, 3'b0, 3'b0);
   endtask

   task automatic load(input logic [1:0] lc, input logic [7:0] ld_d, input string name);
      applyStimulus(1'b0, 3'b111, 1'b0, 1'b1, lc, ld_d, name, 1'b0, 3'b0, 3'b0);
   endtask

   initial begin
      int guard;
      // Cycles 1..10 after reset release: ch0 div 5, ch1 div 3, ch2 div 2
      vecs[0] = '{3'b111, 3'b000, 3'b000};
      vecs[1] = '{3'b111, 3'b100, 3'b100};
      vecs[2] = '{3'b111, 3'b010, 3'b110};
      vecs[3] = '{3'b111, 3'b100, 3'b010};
      vecs[4] = '{3'b111, 3'b001, 3'b011};
      vecs[5] = '{3'b111, 3'b110, 3'b101};
      vecs[6] = '{3'b111, 3'b000, 3'b101};
      vecs[7] = '{3'b111, 3'b100, 3'b001};
      vecs[8] = '{3'b111, 3'b010, 3'b011};
      vecs[9] = '{3'b111, 3'b101, 3'b110};

      $display("[TB] reset");
      applyStimulus(1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, "reset", 1'b1, 3'b000, 3'b000);
      applyStimulus(1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, "reset", 1'b1, 3'b000, 3'b000);

      $display("[TB] table run after reset release");
      for (int v = 0; v < 10; v++)
         applyStimulus(1'b0, vecs[v].en, 1'b0, 1'b0, 2'd0, 8'd0, "table", 1'b1,
                       vecs[v].exp_tick, vecs[v].exp_sq);
      idle(20, 3'b111, "free_run");

      $display("[TB] divisor loads");
      idle(1, 3'b111, "pre_ld");
      load(2'd1, 8'd4, "ld_ch1_div4");
      idle(12, 3'b111, "ch1_div4");
      load(2'd3, 8'd9, "ld_ch3_ignored");
      idle(4, 3'b111, "after_bad_ld");
      load(2'd0, 8'd0, "ld_ch0_div0");
      idle(6, 3'b111, "ch0_halted");
      load(2'd0, 8'd1, "ld_ch0_div1");
      idle(5, 3'b111, "ch0_div1");

      $display("[TB] pause and resume");
      load(2'd0, 8'd5, "ld_ch0_div5");
      idle(2, 3'b111, "count_to_2");
      idle(7, 3'b110, "ch0_paused");
      idle(10, 3'b111, "ch0_resumed");

      $display("[TB] sync with load on terminal count");
      guard = 0;
      while (m_rem[0] != 1 && guard < 10) begin
         idle(1, 3'b111, "seek_term");
         guard++;
      end
      checks++;
      if (m_rem[0] != 1) begin
         errors++;
         $display("[TB] FAIL seek_term: got remaining %0d, required 1", m_rem[0]);
      end
      applyStimulus(1'b0, 3'b111, 1'b1, 1'b1, 2'd2, 8'd7, "sync_ld_ch2", 1'b0, 3'b0, 3'b0);
      idle(16, 3'b111, "after_sync");

      $display("[TB] mid-period reset");
      idle(3, 3'b111, "pre_reset");
      applyStimulus(1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, "mid_reset", 1'b0, 3'b0, 3'b0);
      idle(8, 3'b111, "post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
